uart_tx_serializer: RTL and testbench

- 8N1 asynchronous serial transmitter. It is the transmit-side counterpart to the 16x-oversampled bit-state/bit-count receiver chain.
- Runs on the system clock and advances only on a one-cycle baud-tick pulse, nominally 16 per bit, from the shared clock16 divider.
- Accepts bytes through a one-deep holding register, so the next byte can be queued while the current frame shifts out. Back-to-back frames have no idle gap.

---
 rtl/uart_tx_serializer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter paced by a one-clk tick16 enable.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer #(
    parameter int DATA_BITS     = 8,
    parameter int TICKS_PER_BIT = 16,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick16,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd
);
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + STOP_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t               r_state, w_state;
    logic [DATA_BITS-1:0] r_hold, w_hold;
    logic                 r_hold_full, w_hold_full;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [TW-1:0]        r_tick_cnt, w_tick_cnt;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt;
    logic                 r_txd, w_txd;
    logic                 w_done;
    logic                 w_xfer;
    logic                 w_bit_end;
`ifdef TX_PARITY_EN
    logic                 r_parity, w_parity;
`endif

    assign w_bit_end = tick16 && (r_tick_cnt == TICK_LAST);

    // Next-state logic: bit sequencing, holding-register load and transfer.
    always_comb begin
        w_state     = r_state;
        w_hold      = r_hold;
        w_hold_full = r_hold_full;
        w_shift     = r_shift;
        w_tick_cnt  = r_tick_cnt;
        w_bit_cnt   = r_bit_cnt;
        w_txd       = r_txd;
        w_done      = 1'b0;
        w_xfer      = 1'b0;
`ifdef TX_PARITY_EN
        w_parity    = r_parity;
`endif
        if (tick16 && r_state != S_IDLE)
            w_tick_cnt = w_bit_end ? '0 : r_tick_cnt + TW'(1);
        unique case (r_state)
            S_IDLE: begin
                w_xfer = tick16 && r_hold_full;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state   = S_DATA;
                    w_bit_cnt = '0;
                    w_txd     = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_cnt = '0;
`ifdef TX_PARITY_EN
                        w_state   = S_PARITY;
                        w_txd     = r_parity;
`else
                        w_state   = S_STOP;
                        w_txd     = 1'b1;
`endif
                    end else begin
                        w_bit_cnt = r_bit_cnt + BW'(1);
                        w_shift   = r_shift >> 1;
                        w_txd     = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state   = S_STOP;
                    w_bit_cnt = '0;
                    w_txd     = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_done  = 1'b1;
                        w_xfer  = r_hold_full;
                        w_state = S_IDLE;
                        w_txd   = 1'b1;
                    end else begin
                        w_bit_cnt = r_bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_txd   = 1'b1;
            end
        endcase
        if (tx_load && !r_hold_full) begin
            w_hold      = tx_data;
            w_hold_full = 1'b1;
        end
        if (w_xfer) begin
            w_state     = S_START;
            w_shift     = r_hold;
            w_hold_full = 1'b0;
            w_bit_cnt   = '0;
            w_tick_cnt  = '0;
            w_txd       = 1'b0;
`ifdef TX_PARITY_EN
            w_parity    = ^r_hold;
`endif
        end
    end

    // State register; reset forces the line high with no low glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_txd       <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_hold      <= w_hold;
            r_hold_full <= w_hold_full;
            r_shift     <= w_shift;
            r_tick_cnt  <= w_tick_cnt;
            r_bit_cnt   <= w_bit_cnt;
            r_txd       <= w_txd;
        end
    end

`ifdef TX_PARITY_EN
    // Parity of the frame in flight, captured at transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_parity <= 1'b0;
        else       r_parity <= w_parity;
    end
`endif

    assign tx_ready = !r_hold_full;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = w_done;
    assign txd      = r_txd;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed and random stimulus against a
// frame-position reference model of the UART transmitter.
module tb_uart_tx_serializer;
    localparam int DB  = 8;
    localparam int TPB = 16;
    localparam int SB  = 1;
`ifdef TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int NBITS = 1 + DB + PB + SB;
    localparam int FT    = NBITS * TPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick16 = 1'b0;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, txd;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int low_seen = 0;

    // Reference model: frame position in ticks plus a one-entry hold.
    logic       m_active = 1'b0;
    int         m_ticks = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_hold_full = 1'b0;
    logic [7:0] m_hold = 8'h00;

    uart_tx_serializer #(
        .DATA_BITS(DB), .TICKS_PER_BIT(TPB), .STOP_BITS(SB)
    ) dut (
        .clk(clk), .reset(reset), .tick16(tick16),
        .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .tx_busy(tx_busy),
        .tx_done(tx_done), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return b[idx-1];
        if (PB == 1 && idx == DB + 1) return ^b;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_ticks     = 0;
        m_hold_full = 1'b0;
    endtask

    task automatic model_step(input logic tk, input logic ld,
                              input logic [7:0] d);
        logic acc;
        acc = ld && !m_hold_full;
        if (tk) begin
            if (m_active) begin
                m_ticks++;
                if (m_ticks == FT) begin
                    if (m_hold_full) begin
                        m_byte      = m_hold;
                        m_ticks     = 0;
                        m_hold_full = 1'b0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (m_hold_full) begin
                m_active    = 1'b1;
                m_byte      = m_hold;
                m_ticks     = 0;
                m_hold_full = 1'b0;
            end
        end
        if (acc) begin
            m_hold_full = 1'b1;
            m_hold      = d;
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, step model at posedge.
    task automatic cyc(input logic tk, input logic ld, input logic [7:0] d);
        logic exp_txd, exp_done;
        tick16  = tk;
        tx_load = ld;
        tx_data = d;
        #1;
        exp_txd  = m_active ? frame_bit(m_byte, m_ticks / TPB) : 1'b1;
        exp_done = tk && m_active && (m_ticks == FT - 1);
        chk("txd", 32'(txd), 32'(exp_txd));
        chk("ready", 32'(tx_ready), 32'(!m_hold_full));
        chk("busy", 32'(tx_busy), 32'(m_active));
        chk("done", 32'(tx_done), 32'(exp_done));
        if (tx_done === 1'b1) done_seen++;
        if (txd === 1'b0) low_seen++;
        @(posedge clk);
        model_step(tk, ld, d);
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        tick16  = 1'b1;
        tx_load = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst_pulse();

        // Single byte, tick every clk.
        done_seen = 0;
        cyc(1'b1, 1'b1, 8'h55);
        repeat (199) cyc(1'b1, 1'b0, 8'h00);
        chk("single_dones", 32'(done_seen), 32'd1);

        // Back-to-back frames.
        done_seen = 0;
        cyc(1'b1, 1'b1, 8'hA3);
        repeat (59) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h0F);
        repeat (299) cyc(1'b1, 1'b0, 8'h00);
        chk("b2b_dones", 32'(done_seen), 32'd2);

        // Overrun while ticks are stopped.
        done_seen = 0;
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        cyc(1'b0, 1'b1, 8'h33);
        repeat (5) cyc(1'b0, 1'b0, 8'h00);
        repeat (200) cyc(1'b1, 1'b0, 8'h00);
        chk("overrun_dones", 32'(done_seen), 32'd1);

        // Reset during data bit 3 of 0xF0, then a clean frame.
        done_seen = 0;
        cyc(1'b1, 1'b1, 8'hF0);
        repeat (70) cyc(1'b1, 1'b0, 8'h00);
        rst_pulse();
        chk("abort_dones", 32'(done_seen), 32'd0);
        done_seen = 0;
        cyc(1'b1, 1'b1, 8'h81);
        repeat (199) cyc(1'b1, 1'b0, 8'h00);
        chk("after_rst_dones", 32'(done_seen), 32'd1);

        // Tick every 5 clks with a 50-clk pause mid-frame.
        done_seen = 0;
        low_seen  = 0;
        for (int i = 0; i < 400; i++)
            cyc(1'((i % 5) == 0), 1'(i == 0), 8'h00);
        repeat (50) cyc(1'b0, 1'b0, 8'h00);
        for (int i = 400; i < 1000; i++)
            cyc(1'((i % 5) == 0), 1'b0, 8'h00);
        chk("gate_dones", 32'(done_seen), 32'd1);
        chk("gate_low_clks", 32'(low_seen), 32'((1 + DB) * TPB * 5 + 50));

        // Random traffic with varying tick density.
        for (int seg = 0; seg < 8; seg++) begin
            int dens;
            dens = $urandom_range(3);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(1999) == 0)
                    rst_pulse();
                else
                    cyc(1'($urandom_range(dens) == 0),
                        1'($urandom_range(24) == 0),
                        8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
